// File: rtl/rv64_pkg.sv
// Shared RV64I pipeline types: register-file geometry, writeback beat and
// writeback priority encoding.
package rv64_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic {
        PRIO_LSU,
        PRIO_ALU
    } wb_prio_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_beat_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback sources (ALU, LSU), the arbiter and
// the register file write port. master = source/register-file side, slave = arbiter.
interface regfile_wb_arbiter_if #(
    parameter int unsigned XLEN = 64
);
    logic                                alu_valid;
    logic                                alu_ready;
    logic [rv64_pkg::REG_ADDR_W-1:0]     alu_rd;
    logic [XLEN-1:0]                     alu_data;
    logic                                lsu_valid;
    logic                                lsu_ready;
    logic [rv64_pkg::REG_ADDR_W-1:0]     lsu_rd;
    logic [XLEN-1:0]                     lsu_data;
    logic                                write;
    logic [rv64_pkg::REG_ADDR_W-1:0]     writenum;
    logic [XLEN-1:0]                     write_data;
    logic                                alu_starved;

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready, write, writenum, write_data, alu_starved
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready, write, writenum, write_data, alu_starved
    );

endinterface

// File: rtl/wb_prio_fsm.sv
// Writeback priority FSM: counts consecutive ALU losses and forces ALU priority
// for one grant once STARVE_MAX losses accumulate. Only built with WB_STARVE_GUARD_EN.
module wb_prio_fsm
    import rv64_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     alu_contend,
    input  logic     alu_grant,
    output wb_prio_e prio
);

    localparam logic [3:0] CntLast = 4'(STARVE_MAX - 1);

    wb_prio_e   state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       alu_lose;

    always_comb begin
        alu_lose     = alu_contend && !alu_grant;
        starve_cnt_d = alu_lose ? starve_cnt_q + 4'd1 : 4'd0;
        state_d      = state_q;
        unique case (state_q)
            PRIO_LSU: if (alu_lose && (starve_cnt_q == CntLast)) state_d = PRIO_ALU;
            PRIO_ALU: if (alu_grant) state_d = PRIO_LSU;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PRIO_LSU;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign prio = state_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the ALU and LSU writeback beats onto the single register-file write
// port. Macro WB_STARVE_GUARD_EN enables the ALU anti-starvation priority FSM.
module regfile_wb_arbiter #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    import rv64_pkg::*;

    logic                  alu_contend, lsu_contend;
    logic                  alu_win, lsu_win;
    wb_prio_e              prio;
    logic                  write_q;
    logic [REG_ADDR_W-1:0] writenum_q;
    logic [XLEN-1:0]       write_data_q;

`ifdef WB_STARVE_GUARD_EN
    wb_prio_fsm #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio_fsm (
        .clk         (clk),
        .reset       (reset),
        .alu_contend (alu_contend),
        .alu_grant   (alu_win),
        .prio        (prio)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^STARVE_MAX;
    assign prio       = PRIO_LSU;
`endif

    // x0 beats never contend: they are acked and dropped so the register file
    // never sees a write to index 0.
    always_comb begin
        alu_contend   = bus.alu_valid && (bus.alu_rd != '0);
        lsu_contend   = bus.lsu_valid && (bus.lsu_rd != '0);
        alu_win       = alu_contend && (!lsu_contend || (prio == PRIO_ALU));
        lsu_win       = lsu_contend && !alu_win;
        bus.alu_ready = !reset && ((bus.alu_rd == '0) || alu_win);
        bus.lsu_ready = !reset && ((bus.lsu_rd == '0) || lsu_win);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_q      <= 1'b0;
            writenum_q   <= '0;
            write_data_q <= '0;
        end else begin
            write_q <= alu_win || lsu_win;
            if (alu_win) begin
                writenum_q   <= bus.alu_rd;
                write_data_q <= bus.alu_data;
            end else if (lsu_win) begin
                writenum_q   <= bus.lsu_rd;
                write_data_q <= bus.lsu_data;
            end
        end
    end

    assign bus.write       = write_q;
    assign bus.writenum    = writenum_q;
    assign bus.write_data  = write_data_q;
    assign bus.alu_starved = (prio == PRIO_ALU);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus pushes expected writes, a
// negedge monitor pops and compares every register-file write.
module tb_regfile_wb_arbiter;
    import rv64_pkg::*;

    localparam int unsigned SMax = 4;
`ifdef WB_STARVE_GUARD_EN
    localparam bit Guard = 1'b1;
`else
    localparam bit Guard = 1'b0;
`endif

    logic     clk = 1'b0;
    logic     reset;
    int       vectors = 0;
    int       miscompares = 0;
    wb_beat_t exp_q[$];
    wb_beat_t mon_e;

    bit       a_on, a_pend, lsu_on, exp_a, exp_l;
    int       aidx, lidx;

    regfile_wb_arbiter_if #(.XLEN(64)) bus ();

    regfile_wb_arbiter #(
        .XLEN       (64),
        .STARVE_MAX (SMax)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [63:0] d);
        exp_q.push_back('{rd: rd, data: d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_src();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 64'd0;
        bus.lsu_valid = 1'b0;
        bus.lsu_rd    = 5'd0;
        bus.lsu_data  = 64'd0;
    endtask

    // Monitor: every write must be non-x0 and match the next expected beat.
    always @(negedge clk) begin
        if (bus.write === 1'b1) begin
            chk("write_to_x0", 64'(bus.writenum == 5'd0), 64'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL wb_unexpected: got writenum %0d data %h, expected no write",
                         bus.writenum, bus.write_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_rd", 64'(bus.writenum), 64'(mon_e.rd));
                chk("wb_data", bus.write_data, mon_e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end by 100000");
        $fatal(1);
    end

    initial begin
        // Reset with both sources presenting rd=5.
        reset         = 1'b1;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 64'hA5;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd5;
        bus.lsu_data  = 64'h5A;
        repeat (2) begin
            @(negedge clk);
            chk("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
            chk("rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
            chk("rst_write", 64'(bus.write), 64'd0);
            chk("rst_writenum", 64'(bus.writenum), 64'd0);
            chk("rst_write_data", bus.write_data, 64'd0);
            chk("rst_starved", 64'(bus.alu_starved), 64'd0);
        end
        tick();
        reset = 1'b0;
        idle_src();
        tick();

        // Single ALU beat: 1-cycle latency, one-cycle write pulse.
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_data  = 64'hDEAD_BEEF;
        push(5'd3, 64'hDEAD_BEEF);
        @(negedge clk);
        chk("single_alu_ready", 64'(bus.alu_ready), 64'd1);
        tick();
        idle_src();
        @(negedge clk);
        chk("single_write", 64'(bus.write), 64'd1);
        chk("single_writenum", 64'(bus.writenum), 64'd3);
        tick();
        @(negedge clk);
        chk("single_write_drop", 64'(bus.write), 64'd0);
        tick();

        // x0 discard on LSU while ALU writes r7.
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd0;
        bus.lsu_data  = 64'h111;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd7;
        bus.alu_data  = 64'h222;
        push(5'd7, 64'h222);
        @(negedge clk);
        chk("x0_lsu_ready", 64'(bus.lsu_ready), 64'd1);
        chk("x0_alu_ready", 64'(bus.alu_ready), 64'd1);
        tick();
        idle_src();
        @(negedge clk);
        chk("x0_writenum", 64'(bus.writenum), 64'd7);
        tick();
        @(negedge clk);
        chk("x0_write_drop", 64'(bus.write), 64'd0);
        tick();

        // Same-rd contention: LSU first, ALU holds and follows.
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd9;
        bus.lsu_data  = 64'h1111_0009;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd9;
        bus.alu_data  = 64'h2222_0009;
        push(5'd9, 64'h1111_0009);
        push(5'd9, 64'h2222_0009);
        @(negedge clk);
        chk("cont_lsu_ready", 64'(bus.lsu_ready), 64'd1);
        chk("cont_alu_ready", 64'(bus.alu_ready), 64'd0);
        tick();
        bus.lsu_valid = 1'b0;
        @(negedge clk);
        chk("cont_alu_ready2", 64'(bus.alu_ready), 64'd1);
        chk("cont_first_data", bus.write_data, 64'h1111_0009);
        tick();
        idle_src();
        @(negedge clk);
        chk("cont_second_data", bus.write_data, 64'h2222_0009);
        tick();

        // Starvation: LSU streams 6 beats, ALU offers two beats (r12, r13).
        aidx = 0;
        lidx = 0;
        for (int k = 0; k < 10; k++) begin
            lsu_on = (lidx < 6);
            a_on   = (aidx < 2);
            exp_a  = a_on && ((Guard && (k == 4)) || !lsu_on);
            exp_l  = lsu_on && !exp_a;
            bus.lsu_valid = lsu_on;
            bus.lsu_rd    = 5'(1 + lidx);
            bus.lsu_data  = 64'hB000 + 64'(lidx);
            bus.alu_valid = a_on;
            bus.alu_rd    = 5'(12 + aidx);
            bus.alu_data  = 64'hA000 + 64'(aidx);
            if (exp_a) push(5'(12 + aidx), 64'hA000 + 64'(aidx));
            if (exp_l) push(5'(1 + lidx), 64'hB000 + 64'(lidx));
            @(negedge clk);
            chk("starve_alu_ready", 64'(bus.alu_ready), 64'(exp_a));
            chk("starve_lsu_ready", 64'(bus.lsu_ready), 64'(exp_l));
            chk("starve_flag", 64'(bus.alu_starved), 64'(Guard && (k == 4)));
            tick();
            if (exp_a) aidx++;
            if (exp_l) lidx++;
        end
        idle_src();
        tick();

        // Mid-stream reset after two ALU losses; counter must restart.
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd20;
        bus.alu_data  = 64'hE0;
        lidx = 0;
        for (int m = 0; m < 2; m++) begin
            bus.lsu_valid = 1'b1;
            bus.lsu_rd    = 5'd2;
            bus.lsu_data  = 64'hC00 + 64'(lidx);
            push(5'd2, 64'hC00 + 64'(lidx));
            @(negedge clk);
            chk("mid_pre_alu_ready", 64'(bus.alu_ready), 64'd0);
            chk("mid_pre_lsu_ready", 64'(bus.lsu_ready), 64'd1);
            tick();
            lidx++;
        end
        bus.lsu_data = 64'hC00 + 64'(lidx);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_alu_ready", 64'(bus.alu_ready), 64'd0);
        chk("mid_rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
        tick();
        reset  = 1'b0;
        a_pend = 1'b1;
        lidx   = 0;
        for (int r = 0; r < 8; r++) begin
            lsu_on = (lidx < 5);
            exp_a  = a_pend && ((Guard && (r == 4)) || !lsu_on);
            exp_l  = lsu_on && !exp_a;
            bus.lsu_valid = lsu_on;
            bus.alu_valid = a_pend;
            bus.lsu_data  = 64'hC02 + 64'(lidx);
            if (exp_a) push(5'd20, 64'hE0);
            if (exp_l) push(5'd2, 64'hC02 + 64'(lidx));
            @(negedge clk);
            if (r == 0) begin
                chk("mid_post_write", 64'(bus.write), 64'd0);
                chk("mid_post_writenum", 64'(bus.writenum), 64'd0);
            end
            chk("mid_alu_ready", 64'(bus.alu_ready), 64'(exp_a));
            chk("mid_lsu_ready", 64'(bus.lsu_ready), 64'(exp_l));
            chk("mid_starved", 64'(bus.alu_starved), 64'(Guard && (r == 4)));
            tick();
            if (exp_a) a_pend = 1'b0;
            if (exp_l) lidx++;
        end
        idle_src();
        repeat (3) tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between the two writeback sources of the RV64I pipeline: the ALU and the load/store unit (LSU). Each source presents a valid/ready beat carrying a destination register and 64-bit data. The arbiter grants at most one beat per cycle and drives the register file's `write`, `writenum` and `write_data` from registered outputs. It also guarantees that the register file never sees `write` asserted with `writenum == 0`, since such a write clears the whole array.

## Interface
Parameters:
- `XLEN`, 64, data width of write data.
- `STARVE_MAX`, 4, number of consecutive cycles an ALU beat may lose before it is forced to win. Legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `alu_valid`  in  1  ALU writeback beat present.
- `alu_ready`  out  1  ALU beat accepted this cycle.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `lsu_valid`  in  1  LSU writeback beat present.
- `lsu_ready`  out  1  LSU beat accepted this cycle.
- `lsu_rd`  in  5  LSU destination register.
- `lsu_data`  in  XLEN  load result.
- `write`  out  1  register file write enable (registered).
- `writenum`  out  5  register file write index (registered).
- `write_data`  out  XLEN  register file write data (registered).
- `alu_starved`  out  1  high while the forced-ALU priority state is active.

## Operation
- A beat transfers in any cycle where `x_valid && x_ready`.
- **x0 beats:** when `rd == 0`, `x_ready = 1` whenever `reset = 0`. The beat is discarded, causes no `write` pulse, and takes no part in arbitration. Both sources may discard x0 beats in the same cycle.
- **Contenders:** a source contends only when its `valid = 1` and its `rd != 0`.
- **Priority FSM**, two states:
  - `PRIO_LSU` (reset state): LSU wins when both sources contend.
  - `PRIO_ALU`: ALU wins when both contend.
- **Starvation counter** `starve_cnt`, width 4, reset value 0:
  - Increments each cycle the ALU contends and loses.
  - Clears to 0 whenever the ALU is granted or is not contending.
  - Transition `PRIO_LSU` → `PRIO_ALU` when the ALU loses and `starve_cnt == STARVE_MAX-1`. Forced priority takes effect from the next cycle.
  - Transition `PRIO_ALU` → `PRIO_LSU` the cycle after the ALU is granted.
- A single contender always wins, regardless of FSM state.
- The losing source sees `ready = 0` and must hold its beat stable until accepted.
- **Ordering:** order is preserved within each source. Ordering of writes to the same `rd` across the two sources is the issuing pipeline's responsibility. In the same-`rd` same-cycle case, the winner writes first and the loser writes in a later cycle.
- `alu_starved = (state == PRIO_ALU)`.

## Timing
- `x_ready` is combinational from `x_valid`, `x_rd`, the other source's valid/rd, the FSM state and `reset`. It has no dependence on the outputs.
- **Latency:** 1 cycle. A beat accepted in cycle N drives `write = 1`, `writenum = rd` and `write_data = data` in cycle N+1. The register file commits it at the end of cycle N+1.
- **Throughput:** one non-x0 beat per cycle, sustained.
- `write = 0` in any cycle following a cycle with no grant. `writenum` and `write_data` hold their last values when `write = 0`.
- **Reset:**
  - Registered outputs in the cycle after `reset` is sampled high: `write = 0`, `writenum = 0`, `write_data = 0`, `alu_starved = 0`, `starve_cnt = 0`, state `PRIO_LSU`.
  - While `reset = 1`: `alu_ready = lsu_ready = 0`.
  - If `reset` is asserted in a cycle where a beat would otherwise be granted, that beat is not accepted and no write occurs.
- **Invariant:** `write == 1` implies `writenum != 0`.

## Configuration
- Macro `WB_STARVE_GUARD_EN`.
- **Defined:** the starvation counter, the `PRIO_ALU` state and the `STARVE_MAX` behaviour above are compiled in.
- **Undefined:**
  - Strict fixed priority: LSU always wins a contention.
  - No counter and no FSM; `alu_starved` is tied to 0.
  - `STARVE_MAX` is ignored.
  - All other behaviour is identical.

## Structure
- Shared package `rv64_pkg`:
  - `XLEN = 64`, `REG_ADDR_W = 5`.
  - `typedef enum logic {PRIO_LSU, PRIO_ALU} wb_prio_e`.
  - Struct `wb_beat_t` with fields `rd` and `data`.
- Sub-module `wb_prio_fsm`: holds the starvation counter and priority state. Inputs: `clk`, `reset`, `alu_contend`, `alu_grant`. Output: the current state. The entire sub-module is excluded when `WB_STARVE_GUARD_EN` is undefined.
- The top-level module holds the grant logic, ready generation and output registers.

## Test plan
- **Reset:** hold `reset` for 2 cycles with both sources valid, `rd = 5` → `ready` stays 0; `write = 0`, `writenum = 0`, `write_data = 0` on every cycle after the first.
- **Single beat:** ALU beat `rd = 3`, `data = 64'hDEAD_BEEF` in cycle N → `alu_ready = 1` in N; `write = 1`, `writenum = 3`, `write_data = 64'hDEAD_BEEF` in N+1; `write = 0` in N+2.
- **x0 discard:** LSU `rd = 0` concurrent with ALU `rd = 7` → both ready; exactly one write, to `writenum = 7`; `write` is never high with `writenum = 0`.
- **Contention:** both sources valid, `rd = 9` (LSU) and `rd = 9` (ALU) → LSU is written in N+1 and ALU in N+2, with the ALU holding its beat stable.
- **Starvation:** LSU valid every cycle and ALU valid from cycle 0, with `STARVE_MAX = 4` → ALU loses cycles 0–3, `alu_starved = 1` in cycle 4, ALU granted in cycle 4, LSU regains priority in cycle 5. Without `WB_STARVE_GUARD_EN`, the ALU is never granted.
- **Reset mid-stream:** both sources streaming, `reset` pulsed for 1 cycle → no grant that cycle; FSM returns to `PRIO_LSU` and `starve_cnt = 0`; the stream resumes with LSU priority.
